// File: rtl/dist_ram_fifo.sv
// Synchronous FIFO on inferred LUT RAM; registered flags track count on every edge.
// Latency: 1-cycle registered read, or fall-through when DIST_RAM_FIFO_FWFT_EN is defined.
// Backpressure: writes are refused while full unless a read frees a slot the same cycle.
module dist_ram_fifo #(
  parameter int DATA_WIDTH   = 4,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_LEVEL  = 14,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  wr_acc;
  logic                  rd_acc;

  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  // Async read of mem[rptr] sees the pre-edge contents, so a write into the
  // slot freed by a simultaneous read while full cannot corrupt the popped word.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr] <= wr_data;
  end

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AFULL_C);
      almost_empty <= (count_nxt <= AEMPTY_C);
      overflow     <= wr_en & ~wr_acc;
      underflow    <= rd_en & ~rd_acc;
    end
  end

`ifdef DIST_RAM_FIFO_FWFT_EN
  assign rd_data  = mem[rptr];
  assign rd_valid = ~empty;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= mem[rptr];
    end
  end
`endif

endmodule

// File: tb/tb_dist_ram_fifo.sv
// Scoreboarded bench for dist_ram_fifo: queue-based reference model plus negedge monitor.
module tb_dist_ram_fifo;
  localparam int DW    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, rd_en;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  dist_ram_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LEVEL(14), .AEMPTY_LEVEL(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit active = 0;

  // Reference model: contents as a queue, popped words queued for the monitor.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  bit            m_ovf, m_udf, m_rv;
  logic [DW-1:0] last_seen;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    m_ovf = 0; m_udf = 0; m_rv = 0;
    last_seen = '0;
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      bit ra, wa;
      logic [DW-1:0] w;
      ra = rd_en && (mq.size() > 0);
      wa = wr_en && ((mq.size() < DEPTH) || ra);
      m_ovf = wr_en && !wa;
      m_udf = rd_en && !ra;
      m_rv  = ra;
      if (ra) begin
        w = mq.pop_front();
        exp_q.push_back(w);
      end
      if (wa) mq.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (active && rst_n) begin
      int n;
      n = mq.size();
      chk("count", int'(count), n);
      chk("full", int'(full), int'(n == DEPTH));
      chk("empty", int'(empty), int'(n == 0));
      chk("almost_full", int'(almost_full), int'(n >= 14));
      chk("almost_empty", int'(almost_empty), int'(n <= 2));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("underflow", int'(underflow), int'(m_udf));
`ifdef DIST_RAM_FIFO_FWFT_EN
      exp_q.delete();
      chk("rd_valid", int'(rd_valid), int'(n > 0));
      if (n > 0) chk("rd_data_head", int'(rd_data), int'(mq[0]));
`else
      chk("rd_valid", int'(rd_valid), int'(m_rv));
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected actual %0d expected none", rd_data);
        end else begin
          last_seen = exp_q.pop_front();
          chk("rd_data", int'(rd_data), int'(last_seen));
        end
      end else begin
        chk("rd_data_hold", int'(rd_data), int'(last_seen));
      end
`endif
    end
  end

  task automatic step(input bit we, input bit re, input logic [DW-1:0] d);
    @(negedge clk);
    wr_en = we; rd_en = re; wr_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0);
  endtask

  task automatic chk_reset_state();
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_aempty", int'(almost_empty), 1);
    chk("rst_afull", int'(almost_full), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_udf", int'(underflow), 0);
`ifndef DIST_RAM_FIFO_FWFT_EN
    chk("rst_rd_data", int'(rd_data), 0);
`endif
  endtask

  initial begin
    logic [DW-1:0] d;
    wr_en = 0; rd_en = 0; wr_data = '0;
    model_clear();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2 chk_reset_state();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    active = 1;

    // Fill with 1..F,0, then overflow attempt, then full drain.
    for (int i = 1; i <= 16; i++) begin
      d = DW'(i);
      step(1, 0, d);
    end
    step(1, 0, 4'h5);
    for (int i = 0; i < 16; i++) step(0, 1, '0);
    idle(2);

    // Partial traffic then a full pass across the pointer wrap.
    for (int i = 0; i < 10; i++) begin d = DW'(i + 3); step(1, 0, d); end
    for (int i = 0; i < 10; i++) step(0, 1, '0);
    for (int i = 0; i < 16; i++) begin d = DW'(i); step(1, 0, d); end
    for (int i = 0; i < 16; i++) step(0, 1, '0);
    idle(2);

    // Simultaneous read and write while full.
    for (int i = 0; i < 16; i++) begin d = DW'(15 - i); step(1, 0, d); end
    step(1, 1, 4'hA);
    for (int i = 0; i < 16; i++) step(0, 1, '0);
    idle(2);

    // Simultaneous read and write while empty.
    step(1, 1, 4'h3);
    step(0, 0, '0);
    step(0, 1, '0);
    idle(2);

    // Asynchronous reset with 7 entries held.
    for (int i = 0; i < 7; i++) begin d = DW'(i + 8); step(1, 0, d); end
    @(negedge clk);
    wr_en = 0; rd_en = 0;
    #2 rst_n = 1'b0;
    #1 model_clear();
    chk_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 4'h9);
    step(0, 1, '0);
    idle(2);

    // Random traffic with write bias swept to visit full and empty.
    for (int ph = 0; ph < 8; ph++) begin
      int wp;
      wp = (ph % 2 == 0) ? 80 : 20;
      for (int i = 0; i < 200; i++) begin
        d = DW'($urandom_range(0, 15));
        step(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) >= wp), d);
      end
    end
    for (int i = 0; i < 300; i++) begin
      d = DW'($urandom_range(0, 15));
      step(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), d);
    end
    for (int i = 0; i < 20; i++) step(0, 1, '0);
    idle(3);

    chk("pending_reads", exp_q.size(), 0);
    active = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dist_ram_fifo.md
Name: dist_ram_fifo

Overview:
- Parametrised synchronous FIFO built on inferred distributed (LUT) RAM: one write port, one asynchronous-read port.
- Generalises the fixed 16x4 dual-port LUT RAM to any width and depth. Adds pointer management, occupancy count, full/empty/almost flags and error pulses.
- Used as the small rate-matching buffer between single-clock pipeline stages. Depth is kept at or below 64 so it stays in LUT RAM.

Parameters:
- DATA_WIDTH, 4, bits per entry
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH; legal range 2..6
- AFULL_LEVEL, 14, almost_full asserts when count >= AFULL_LEVEL
- AEMPTY_LEVEL, 2, almost_empty asserts when count <= AEMPTY_LEVEL

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  write request
- wr_data  input  DATA_WIDTH  write data
- rd_en  input  1  read request (acknowledge in FWFT mode)
- rd_data  output  DATA_WIDTH  read data
- rd_valid  output  1  rd_data holds a popped word
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  count >= AFULL_LEVEL
- almost_empty  output  1  count <= AEMPTY_LEVEL
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  output  1  one-cycle pulse on a rejected write
- underflow  output  1  one-cycle pulse on a rejected read

Behaviour:
- Reset: asynchronous and active-low. On assertion of rst_n:
  - wptr, rptr and count go to 0.
  - rd_data goes to 0 (standard mode only).
  - rd_valid, overflow and underflow go to 0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - RAM contents are not reset.
  - Reset during traffic discards all entries; the first write after release goes to address 0.
- Flags are registered, not decoded from pointers combinationally. Each flag is updated in the same edge as count, so it always matches count.
- Write acceptance: wr_acc = wr_en & (~full | rd_acc).
  - On wr_acc, mem[wptr] is written with wr_data and wptr increments modulo DEPTH.
- Read acceptance: rd_acc = rd_en & ~empty.
  - On rd_acc, rptr increments modulo DEPTH.
  - Standard mode: rd_data is registered with mem[rptr] on the same edge, and rd_valid=1 for the following cycle.
  - Standard read latency is 1 cycle. rd_data holds its value when there is no read.
- Count update:
  - wr_acc only: count+1.
  - rd_acc only: count-1.
  - Both, or neither: unchanged.
- Full with simultaneous read and write: both are accepted and count stays at DEPTH.
  - The read returns the old head word; the new word is written to the freed slot (wptr == rptr).
  - The read must sample the RAM before the write takes effect (async read, synchronous write).
- Empty with simultaneous read and write: the write is accepted, the read is rejected, and underflow pulses.
- overflow = wr_en & ~wr_acc, registered as a 1-cycle pulse.
- underflow = rd_en & ~rd_acc, registered as a 1-cycle pulse.
- A rejected operation changes no state.
- Pointers wrap from DEPTH-1 to 0 with no special case. Full and empty are resolved by count, not by pointer equality.
- Worst-case throughput: one write and one read per cycle, sustained indefinitely.

Optional Feature:
- Macro: DIST_RAM_FIFO_FWFT_EN
- Defined (first-word fall-through):
  - rd_data = mem[rptr] combinationally from the async read port, and rd_valid = ~empty.
  - rd_en acts as acknowledge and pops the head word in the same cycle it is presented.
  - A word written into an empty FIFO appears on rd_data with rd_valid=1 one cycle after the write edge.
  - There is no rd_data register, and rd_data is undefined while empty.
- Not defined: the standard 1-cycle registered read described above.
- Flags, count and error pulses are identical in both modes.

Test Plan:
- Reset then fill: release rst_n, write 0x1..0xF and 0x0 (16 words) → count steps 1..16; almost_full first at count=14; full=1 after the 16th; no overflow.
- Write 0x5 while full with rd_en=0 → overflow pulses 1 cycle; count stays 16; a later full drain returns 0x1..0xF, 0x0 unchanged.
- Drain and wrap: write 10 words, read 10, then write 16 more (0x0..0xF) and read all → data is in order across the pointer wrap; empty=1 at the end.
- Full with simultaneous rd_en and wr_en (data 0xA) → standard mode returns the old head next cycle with rd_valid=1; count stays 16; 0xA comes out last.
- Empty with simultaneous rd_en and wr_en (data 0x3) → underflow pulses; count becomes 1; the next read returns 0x3. In FWFT mode, 0x3 is on rd_data with rd_valid=1 the cycle after the write.
- Reset mid-traffic: assert rst_n low asynchronously with count=7 → all flags and count go to their reset values immediately without a clock edge; after release, write 0x9 and read → returns 0x9.
